// File: rtl/fifo_pkg.sv
// Shared constants for the parametrised FIFO: default geometry, pointer-width
// helper and status-flag bit positions used when the four flags are packed.
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH_DEF = 32;
  localparam int unsigned FIFO_DEPTH_DEF = 8;

  // Pointer width for a power-of-two depth; never below 1 bit.
  function automatic int unsigned fifo_aw(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  typedef enum int unsigned {
    ST_WR_ACK = 0,
    ST_WR_ERR = 1,
    ST_RD_ACK = 2,
    ST_RD_ERR = 3
  } status_bit_e;

  localparam int unsigned ST_NUM = 4;

endpackage

// File: rtl/fifo_rd_mux.sv
// Generic DEPTH-to-1, WIDTH-bit combinational read selector.
module fifo_rd_mux
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_WIDTH_DEF,
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned AW    = fifo_aw(DEPTH)
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] data,
  input  logic [AW-1:0]               sel,
  output logic [WIDTH-1:0]            q
);

  always_comb begin
    q = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sel == AW'(i)) q = data[i];
    end
  end

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with registered read data and per-request
// ack/err pulses. Define FIFO_ALMOST_EN to add almost_full/almost_empty.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = FIFO_WIDTH_DEF,
  parameter int unsigned DEPTH    = FIFO_DEPTH_DEF,
`ifdef FIFO_ALMOST_EN
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1,
`endif
  localparam int unsigned AW      = fifo_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      data_count,
  output logic             wr_ack,
  output logic             wr_err,
  output logic             rd_ack,
  output logic             rd_err
`ifdef FIFO_ALMOST_EN
  ,
  output logic             almost_full,
  output logic             almost_empty
`endif
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr;
  logic [AW-1:0]               rd_ptr;
  logic [WIDTH-1:0]            rd_data;
  logic                        wr_acc;
  logic                        rd_acc;

  assign full   = (data_count == (AW+1)'(DEPTH));
  assign empty  = (data_count == '0);
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

`ifdef FIFO_ALMOST_EN
  assign almost_full  = (data_count >= (AW+1)'(AF_LEVEL));
  assign almost_empty = (data_count <= (AW+1)'(AE_LEVEL));
`endif

  fifo_rd_mux #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_rd_mux (
    .data (mem),
    .sel  (rd_ptr),
    .q    (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mem        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
      dout       <= '0;
      wr_ack     <= 1'b0;
      wr_err     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      if (wr_acc) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        dout   <= rd_data;
        rd_ptr <= rd_ptr + AW'(1);
      end
      // Acceptance is judged on the pre-edge count, so a full FIFO never
      // folds a write into the slot freed by a simultaneous read.
      case ({wr_acc, rd_acc})
        2'b10:   data_count <= data_count + (AW+1)'(1);
        2'b01:   data_count <= data_count - (AW+1)'(1);
        default: data_count <= data_count;
      endcase
      wr_ack <= wr_acc;
      wr_err <= wr_en && !wr_acc;
      rd_ack <= rd_acc;
      rd_err <= rd_en && !rd_acc;
    end
  end

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: queue-based reference model compared
// every cycle, plus directed literal expectations.
module tb_fifo_param;
  import fifo_pkg::*;

  localparam int unsigned W  = FIFO_WIDTH_DEF;
  localparam int unsigned D  = FIFO_DEPTH_DEF;
  localparam int unsigned AW = fifo_aw(D);

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [W-1:0]  din;
  logic          rd_en;
  logic [W-1:0]  dout;
  logic          full;
  logic          empty;
  logic [AW:0]   data_count;
  logic          wr_ack, wr_err, rd_ack, rd_err;
`ifdef FIFO_ALMOST_EN
  logic          almost_full, almost_empty;
`endif

  fifo_param #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .data_count   (data_count),
    .wr_ack       (wr_ack),
    .wr_err       (wr_err),
    .rd_ack       (rd_ack),
    .rd_err       (rd_err)
`ifdef FIFO_ALMOST_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus last-read word and flags.
  logic [W-1:0]      m_q[$];
  logic [W-1:0]      m_dout;
  logic [ST_NUM-1:0] m_st;

  always @(posedge clk) begin
    bit wa, ra;
    if (reset) begin
      m_q.delete();
      m_dout = '0;
      m_st   = '0;
    end else begin
      wa = wr_en && (m_q.size() < D);
      ra = rd_en && (m_q.size() > 0);
      if (ra) m_dout = m_q.pop_front();
      if (wa) m_q.push_back(din);
      m_st = '0;
      m_st[ST_WR_ACK] = wa;
      m_st[ST_WR_ERR] = wr_en && !wa;
      m_st[ST_RD_ACK] = ra;
      m_st[ST_RD_ERR] = rd_en && !ra;
    end
  end

  logic [ST_NUM-1:0] dut_st;
  always_comb begin
    dut_st = '0;
    dut_st[ST_WR_ACK] = wr_ack;
    dut_st[ST_WR_ERR] = wr_err;
    dut_st[ST_RD_ACK] = rd_ack;
    dut_st[ST_RD_ERR] = rd_err;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_count", 64'(data_count), 64'(m_q.size()));
      chk("m_full",  64'(full),  64'(m_q.size() == D));
      chk("m_empty", 64'(empty), 64'(m_q.size() == 0));
      chk("m_dout",  64'(dout),  64'(m_dout));
      chk("m_status", 64'(dut_st), 64'(m_st));
`ifdef FIFO_ALMOST_EN
      chk("m_afull",  64'(almost_full),  64'(m_q.size() >= D - 1));
      chk("m_aempty", 64'(almost_empty), 64'(m_q.size() <= 1));
`endif
    end
  end

  // Drive one cycle of requests at a negedge, return at the next negedge.
  task automatic step(input logic w, input logic [W-1:0] d, input logic r);
    wr_en = w;
    din   = d;
    rd_en = r;
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    wr_en = 1'b1;
    din   = 32'hDEAD;
    rd_en = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
    wr_en  = 1'b0;
    chk_en = 1'b1;

    // Reset dominates the concurrent write.
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full",  64'(full),  64'd0);
    chk("rst_count", 64'(data_count), 64'd0);
    chk("rst_dout",  64'(dout), 64'd0);
    chk("rst_flags", 64'({wr_ack, wr_err, rd_ack, rd_err}), 64'd0);
    step(1'b0, '0, 1'b1);
    chk("rst_nostore_rderr", 64'(rd_err), 64'd1);
    chk("rst_nostore_dout",  64'(dout), 64'd0);

    // Fill, then overflow.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, W'(32'h10 + i), 1'b0);
      chk("fill_wrack", 64'(wr_ack), 64'd1);
`ifdef FIFO_ALMOST_EN
      chk("fill_afull",  64'(almost_full),  64'(i + 1 >= 7));
      chk("fill_aempty", 64'(almost_empty), 64'(i + 1 <= 1));
`endif
    end
    chk("fill_full",  64'(full), 64'd1);
    chk("fill_count", 64'(data_count), 64'd8);
    step(1'b1, 32'h18, 1'b0);
    chk("ovf_wrerr", 64'(wr_err), 64'd1);
    chk("ovf_wrack", 64'(wr_ack), 64'd0);
    chk("ovf_count", 64'(data_count), 64'd8);
    step(1'b0, '0, 1'b0);
    chk("ovf_pulse", 64'(wr_err), 64'd0);

    // Drain, then underflow.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0, 1'b1);
      chk("drain_dout",  64'(dout), 64'(32'h10 + i));
      chk("drain_rdack", 64'(rd_ack), 64'd1);
    end
    step(1'b0, '0, 1'b1);
    chk("udf_rderr", 64'(rd_err), 64'd1);
    chk("udf_dout",  64'(dout), 64'h17);
    chk("udf_empty", 64'(empty), 64'd1);

    // Pointer rollover.
    for (int i = 0; i < 5; i++) step(1'b1, W'(32'hA0 + i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b1);
      chk("wrap5_dout", 64'(dout), 64'(32'hA0 + i));
    end
    for (int i = 0; i < 6; i++) step(1'b1, W'(32'hB0 + i), 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, 1'b1);
      chk("wrap6_dout", 64'(dout), 64'(32'hB0 + i));
    end
    chk("wrap_count", 64'(data_count), 64'd0);

    // Simultaneous read/write at count 3, 8 and 0.
    for (int i = 0; i < 3; i++) step(1'b1, W'(32'hC0 + i), 1'b0);
    step(1'b1, 32'hC3, 1'b1);
    chk("sim3_acks",  64'({wr_ack, rd_ack}), 64'b11);
    chk("sim3_count", 64'(data_count), 64'd3);
    chk("sim3_dout",  64'(dout), 64'hC0);
    for (int i = 0; i < 5; i++) step(1'b1, W'(32'hD0 + i), 1'b0);
    chk("sim8_pre",   64'(data_count), 64'd8);
    step(1'b1, 32'hEE, 1'b1);
    chk("sim8_rdack", 64'(rd_ack), 64'd1);
    chk("sim8_wrerr", 64'(wr_err), 64'd1);
    chk("sim8_count", 64'(data_count), 64'd7);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1);
    chk("sim0_pre",   64'(data_count), 64'd0);
    step(1'b1, 32'hF0, 1'b1);
    chk("sim0_wrack", 64'(wr_ack), 64'd1);
    chk("sim0_rderr", 64'(rd_err), 64'd1);
    chk("sim0_count", 64'(data_count), 64'd1);
    step(1'b0, '0, 1'b1);
    chk("sim0_dout",  64'(dout), 64'hF0);
    step(1'b0, '0, 1'b0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised synchronous FIFO: the next-generation successor of the fixed 8 x 32-bit register-file FIFO.
- Storage width and depth are generic.
- Read data is registered; the read selector is a generic N-to-1 mux.
- Per-request acknowledge/error status is produced.
- Sits between producer and consumer blocks in one clock domain.

Parameters:
WIDTH, 32, data word width in bits
DEPTH, 8, number of entries; power of two, minimum 2
AW, $clog2(DEPTH), pointer width (derived; do not override)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
wr_en  in  1  write request
din  in  WIDTH  write data
rd_en  in  1  read request
dout  out  WIDTH  registered read data
full  out  1  count == DEPTH
empty  out  1  count == 0
data_count  out  AW+1  number of stored entries, range 0..DEPTH
wr_ack  out  1  previous-cycle write accepted
wr_err  out  1  previous-cycle write rejected (full)
rd_ack  out  1  previous-cycle read accepted; dout valid this cycle
rd_err  out  1  previous-cycle read rejected (empty)

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (sampled at clk edge) values:
  - wr_ptr = rd_ptr = 0, data_count = 0.
  - dout = 0, all ack/err = 0.
  - empty = 1, full = 0.
  - Storage cleared to 0.
  - Reset wins over any request in the same cycle; requests in that cycle are dropped with no ack/err.
- Write accept: wr_en && !full. Otherwise, with wr_en=1, wr_err=1 next cycle and no state change. An accepted write stores din at mem[wr_ptr] and does wr_ptr+1 mod DEPTH.
- Read accept: rd_en && !empty. Otherwise, with rd_en=1, rd_err=1 next cycle. An accepted read loads dout <= mem[rd_ptr] and does rd_ptr+1 mod DEPTH.
- Read latency: 1 cycle. dout updates at the edge the read is accepted and is valid while rd_ack=1. dout holds its value when no read is accepted.
- Simultaneous rd_en and wr_en:
  - Neither full nor empty: both accepted; data_count unchanged; wr_ack = rd_ack = 1.
  - Full: read accepted, write rejected (wr_err=1). The write is not folded into the freed slot.
  - Empty: write accepted, read rejected (rd_err=1). There is no write-through; new data is readable next cycle.
- data_count: +1 on write-only accept, -1 on read-only accept.
- full/empty: decoded combinationally from the registered data_count.
- Ack/err flags:
  - Each flag is a one-cycle pulse, registered, independent per direction.
  - Both flags of one direction are never 1 together.
  - A flag is 0 when that direction had no request.
- Pointer wrap: natural AW-bit rollover. Full/empty discrimination relies solely on data_count.
- Storage and read mux are indexed only by pointers, so there is no out-of-range access.

Optional Feature:
- Macro: FIFO_ALMOST_EN.
- When defined:
  - Adds parameters AF_LEVEL (default DEPTH-1) and AE_LEVEL (default 1).
  - Adds outputs almost_full (data_count >= AF_LEVEL) and almost_empty (data_count <= AE_LEVEL), both combinational from data_count.
  - Reset values: almost_full = 0, almost_empty = 1.
- When undefined: those ports and parameters do not exist; all other behaviour is identical.

Decomposition:
- Package fifo_pkg holds:
  - default WIDTH/DEPTH constants;
  - a function computing AW;
  - the status-flag bit positions used by the bench scoreboard.
- Sub-module fifo_rd_mux is the generalised DEPTH-to-1, WIDTH-bit combinational selector (sel width AW). The registered dout stays in fifo_param.

Test Plan:
- Reset with wr_en=1, din=32'hDEAD -> next cycle: empty=1, data_count=0, dout=0, no ack/err; the write is not stored.
- Write 8 words 32'h10..32'h17, then a 9th write 32'h18 -> full=1, data_count=8. The 9th write gives wr_err=1 for one cycle; count stays 8.
- Read 8 times -> dout sequence 32'h10..32'h17, each with rd_ack=1 and 1-cycle latency. A 9th read gives rd_err=1, dout holds 32'h17, empty=1.
- Wrap: write 5, read 5, write 6, read 6 -> data returned in order across the pointer rollover; count returns to 0.
- Simultaneous rd+wr:
  - count=3: wr_ack = rd_ack = 1, count stays 3.
  - count=8: rd_ack=1, wr_err=1, count becomes 7.
  - count=0: wr_ack=1, rd_err=1, count becomes 1.
- FIFO_ALMOST_EN with DEPTH=8 and default levels: almost_full rises at count 7; almost_empty is 1 at counts 0 and 1 and falls at 2.
